// File: rtl/jpeg_pkg.sv
// Shared types and helpers for the JPEG frame sequencer: FSM states, FIFO entry
// layout, marker constants and the tail padding mask.
package jpeg_pkg;

    typedef enum logic [2:0] {IDLE, HEADER, STREAM, TAIL0, TAIL1, DRAIN} seq_state_t;

    typedef struct packed {
        logic [31:0] word;
        logic [3:0]  keep;
    } fifo_ent_t;

    localparam logic [15:0] EOI_MARKER = 16'hFFD9;
    localparam logic [7:0]  STUFF_BYTE = 8'h00;

    function automatic logic [2:0] byte_count(input logic [4:0] bits);
        return {1'b0, bits[4:3]} + {2'b00, |bits[2:0]};
    endfunction

    // Ones in the unused low bits of the last partial byte; zero when byte aligned.
    function automatic logic [31:0] pad_mask(input logic [4:0] bits);
        logic [5:0] used_bits;
        used_bits = {byte_count(bits), 3'b000};
        return (32'hFFFF_FFFF >> bits) & ~(32'hFFFF_FFFF >> used_bits);
    endfunction

endpackage

// File: rtl/jpeg_word_fifo.sv
// First-word fall-through FIFO of word+keep entries; pointers carry an extra wrap
// bit so full and empty are distinguished without a counter register.
module jpeg_word_fifo
    import jpeg_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  fifo_ent_t                push_ent_i,
    input  logic                     pop_i,
    output fifo_ent_t                head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    fifo_ent_t         mem_q [DEPTH];
    logic [AW:0]       wr_q, rd_q;
    logic              do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count_o = wr_q - rd_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_ent_i;
    end

endmodule

// File: rtl/jpeg_frame_sequencer.sv
// Frame controller: header words, stuffed entropy words, then a padded tail carrying
// the EOI marker, all funnelled through a valid/ready word FIFO.
module jpeg_frame_sequencer
    import jpeg_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] hdr_word,
    input  logic        hdr_valid,
    input  logic        hdr_last,
    output logic        hdr_ready,
    input  logic [31:0] enc_word,
    input  logic        enc_valid,
    input  logic        eof_partial,
    input  logic [4:0]  eof_bits,
    output logic [31:0] out_word,
    output logic [3:0]  out_keep,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        overflow_err
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    seq_state_t       state_q, state_d;
    fifo_ent_t        tail0_q, tail0_d, tail1_q, tail1_d;
    logic             two_q, two_d;
    logic             ovf_q, ovf_d;

    logic             push, pop, full, empty;
    fifo_ent_t        push_ent, head;
    logic [CW-1:0]    fifo_count;

    // Tail assembly from the current enc_word/eof_bits, captured on eof_partial.
    logic [2:0]       k, pos, n;
    logic [5:0]       kbits;
    logic [31:0]      data_w;
    logic [7:0]       last_byte;
    logic             stuff;
    logic [63:0]      tail_buf;
    logic [3:0]       keep0, keep1;

    always_comb begin
        k         = byte_count(eof_bits);
        kbits     = {k, 3'b000};
        data_w    = (enc_word & ~(32'hFFFF_FFFF >> kbits)) | pad_mask(eof_bits);
        last_byte = 8'(data_w >> (6'd32 - kbits));
        stuff     = (eof_bits[2:0] != 3'd0) && (last_byte == 8'hFF);
        pos       = k + {2'b00, stuff};
        n         = pos + 3'd2;
        tail_buf  = {data_w, 32'h0} | ({EOI_MARKER, 48'h0} >> {pos, 3'b000});
        if (stuff) tail_buf = tail_buf | ({STUFF_BYTE, 56'h0} >> {k, 3'b000});
        keep0     = (n >= 3'd4) ? 4'hF : 4'hF << (3'd4 - n);
        keep1     = (n >  3'd4) ? 4'hF << (4'd8 - {1'b0, n}) : 4'h0;
    end

    assign out_valid    = !empty;
    assign pop          = out_valid && out_ready;
    assign out_word     = head.word;
    assign out_keep     = head.keep;
    assign busy         = (state_q != IDLE);
    assign overflow_err = ovf_q;

    always_comb begin
        state_d    = state_q;
        tail0_d    = tail0_q;
        tail1_d    = tail1_q;
        two_d      = two_q;
        ovf_d      = ovf_q;
        hdr_ready  = 1'b0;
        push       = 1'b0;
        push_ent   = '0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = HEADER;
                ovf_d   = 1'b0;
            end
            HEADER: begin
                hdr_ready = !full;
                if (hdr_valid && !full) begin
                    push     = 1'b1;
                    push_ent = '{word: hdr_word, keep: 4'hF};
                    if (hdr_last) state_d = STREAM;
                end
            end
            STREAM: begin
                if (enc_valid) begin
                    if (!full) begin
                        push     = 1'b1;
                        push_ent = '{word: enc_word, keep: 4'hF};
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (eof_partial) begin
                    tail0_d = '{word: tail_buf[63:32], keep: keep0};
                    tail1_d = '{word: tail_buf[31:0],  keep: keep1};
                    two_d   = (n > 3'd4);
                    state_d = TAIL0;
                end
            end
            TAIL0: if (!full) begin
                push     = 1'b1;
                push_ent = tail0_q;
                state_d  = two_q ? TAIL1 : DRAIN;
            end
            TAIL1: if (!full) begin
                push     = 1'b1;
                push_ent = tail1_q;
                state_d  = DRAIN;
            end
            DRAIN: if (pop && fifo_count == CW'(1)) begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tail0_q <= '0;
            tail1_q <= '0;
            two_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tail0_q <= tail0_d;
            tail1_q <= tail1_d;
            two_q   <= two_d;
            ovf_q   <= ovf_d;
        end
    end

    jpeg_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_ent_i (push_ent),
        .pop_i      (pop),
        .head_o     (head),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (fifo_count)
    );

endmodule

// File: tb/tb_jpeg_frame_sequencer.sv
// Scoreboard bench: stimulus queues expected output words, a negedge monitor pops
// and compares them whenever the sink accepts a word.
module tb_jpeg_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] hdr_word = '0;
    logic        hdr_valid = 1'b0, hdr_last = 1'b0, hdr_ready;
    logic [31:0] enc_word = '0;
    logic        enc_valid = 1'b0, eof_partial = 1'b0;
    logic [4:0]  eof_bits = '0;
    logic [31:0] out_word;
    logic [3:0]  out_keep;
    logic        out_valid, out_ready = 1'b0;
    logic        busy, frame_done, overflow_err;

    typedef struct {
        logic [31:0] w;
        logic [3:0]  k;
        bit          last;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    jpeg_frame_sequencer #(.FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .hdr_word(hdr_word), .hdr_valid(hdr_valid), .hdr_last(hdr_last), .hdr_ready(hdr_ready),
        .enc_word(enc_word), .enc_valid(enc_valid), .eof_partial(eof_partial), .eof_bits(eof_bits),
        .out_word(out_word), .out_keep(out_keep), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .frame_done(frame_done), .overflow_err(overflow_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h expected none", out_word);
                end else begin
                    e = sb.pop_front();
                    chk("out_word", out_word, e.w);
                    chk("out_keep", 32'(out_keep), 32'(e.k));
                    chk("frame_done_on_pop", 32'(frame_done), 32'(e.last));
                end
            end else if (frame_done) begin
                checks++;
                errors++;
                $display("FAIL stray_frame_done: got 1 expected 0");
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] w, input logic [3:0] k, input bit last);
        exp_t e;
        e.w = w; e.k = k; e.last = last;
        sb.push_back(e);
    endtask

    task automatic begin_frame();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] w, input logic last);
        int n;
        n = 0;
        hdr_word = w; hdr_last = last; hdr_valid = 1'b1;
        while (!hdr_ready && n < 100) begin
            cyc();
            n++;
        end
        if (!hdr_ready) begin
            checks++;
            errors++;
            $display("FAIL hdr_ready_timeout: got 0 expected 1");
        end
        expect_word(w, 4'hF, 1'b0);
        cyc();
        hdr_valid = 1'b0; hdr_last = 1'b0;
    endtask

    task automatic send_enc(input logic [31:0] w, input bit kept);
        enc_word = w; enc_valid = 1'b1;
        if (kept) expect_word(w, 4'hF, 1'b0);
        cyc();
        enc_valid = 1'b0;
    endtask

    task automatic send_eof(input logic [4:0] bits, input logic [31:0] w, input bit with_full,
                            input logic [31:0] t0, input logic [3:0] k0, input bit two,
                            input logic [31:0] t1, input logic [3:0] k1);
        enc_word = w; eof_bits = bits; eof_partial = 1'b1; enc_valid = with_full;
        if (with_full) expect_word(w, 4'hF, 1'b0);
        expect_word(t0, k0, !two);
        if (two) expect_word(t1, k1, 1'b1);
        cyc();
        eof_partial = 1'b0; enc_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 300) begin
            cyc();
            n++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        repeat (2) cyc();
        chk("rst_hdr_ready", 32'(hdr_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_overflow", 32'(overflow_err), 32'd0);
        chk("rst_out_word", out_word, 32'd0);
        chk("rst_out_keep", 32'(out_keep), 32'd0);
        rst = 1'b0;
        cyc();

        // 3 header words, 5 entropy words, 12-bit tail
        out_ready = 1'b1;
        begin_frame();
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) send_hdr(32'hFFD8_0000 + i, i == 2);
        for (int i = 0; i < 5; i++) send_enc(32'h1000_0000 + i, 1'b1);
        send_eof(5'd12, 32'hABC0_0000, 1'b0, 32'hABCF_FFD9, 4'hF, 1'b0, 32'h0, 4'h0);
        wait_idle("t1_idle");

        // byte-aligned and empty tails
        begin_frame();
        send_hdr(32'hAAAA_0001, 1'b1);
        send_eof(5'd8, 32'h1200_0000, 1'b0, 32'h12FF_D900, 4'hE, 1'b0, 32'h0, 4'h0);
        wait_idle("t2a_idle");
        begin_frame();
        send_hdr(32'hAAAA_0002, 1'b1);
        send_eof(5'd0, 32'h5555_5555, 1'b0, 32'hFFD9_0000, 4'hC, 1'b0, 32'h0, 4'h0);
        wait_idle("t2b_idle");

        // padding produces 0xFF, so a stuff byte follows
        begin_frame();
        send_hdr(32'hAAAA_0003, 1'b1);
        send_eof(5'd28, 32'h1234_5FF0, 1'b0, 32'h1234_5FFF, 4'hF, 1'b1, 32'h00FF_D900, 4'hE);
        wait_idle("t3_idle");

        // overflow: sink stalled, 12 words into an 8-deep FIFO
        begin_frame();
        send_hdr(32'hAAAA_0004, 1'b1);
        repeat (3) cyc();
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) send_enc(32'hC000_0000 + i, i < 8);
        chk("t4_overflow_set", 32'(overflow_err), 32'd1);
        send_eof(5'd8, 32'h7700_0000, 1'b0, 32'h77FF_D900, 4'hE, 1'b0, 32'h0, 4'h0);
        repeat (2) cyc();
        chk("t4_stall_busy", 32'(busy), 32'd1);
        out_ready = 1'b1;
        wait_idle("t4_idle");
        chk("t4_overflow_sticky", 32'(overflow_err), 32'd1);

        // full word with eof in one cycle, tail stalls on full FIFO, sink toggles
        out_ready = 1'b0;
        begin_frame();
        chk("t5_overflow_cleared", 32'(overflow_err), 32'd0);
        send_hdr(32'hAAAA_0005, 1'b1);
        for (int i = 0; i < 6; i++) send_enc(32'hD000_0000 + i, 1'b1);
        send_eof(5'd20, 32'h1234_5678, 1'b1, 32'h1234_5FFF, 4'hF, 1'b1, 32'hD900_0000, 4'h8);
        n = 0;
        while (busy && n < 300) begin
            out_ready = ~out_ready;
            cyc();
            n++;
        end
        out_ready = 1'b1;
        chk("t5_idle", 32'(busy), 32'd0);
        chk("t5_no_overflow", 32'(overflow_err), 32'd0);

        // reset mid-frame flushes everything
        out_ready = 1'b0;
        begin_frame();
        send_hdr(32'hAAAA_0006, 1'b1);
        for (int i = 0; i < 3; i++) send_enc(32'hE000_0000 + i, 1'b1);
        chk("t6_valid_before_rst", 32'(out_valid), 32'd1);
        rst = 1'b1;
        sb.delete();
        cyc();
        rst = 1'b0;
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_frame_done", 32'(frame_done), 32'd0);
        out_ready = 1'b1;
        begin_frame();
        send_hdr(32'hAAAA_0007, 1'b1);
        send_enc(32'hF000_0001, 1'b1);
        send_eof(5'd0, 32'h0, 1'b0, 32'hFFD9_0000, 4'hC, 1'b0, 32'h0, 4'h0);
        wait_idle("t6_idle");
        repeat (2) cyc();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
